// File: rtl/inv_round_tail.sv
// inv_round_tail: AddRoundKey + InvMixColumns tail of one AES-128 inverse round, valid/ready on both sides.
// Define INV_MIX_PIPE2_EN for two register stages (latency 2); otherwise one stage (latency 1).
module inv_round_tail #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_state,
  input  logic [127:0]     in_key,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_state,
  output logic             out_last,
  output logic [CNT_W-1:0] blk_cnt
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // 0e = 8^4^2, 0b = 8^2^1, 0d = 8^4^1, 09 = 8^1, built from shared xtime chains
  function automatic logic [31:0] invMixCol(input logic [31:0] col);
    logic [7:0]  a  [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [1:0]  i1, i2, i3;
    logic [31:0] res;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[8*r +: 8];
      x2[r] = xtime(a[r]);
      x4[r] = xtime(x2[r]);
      x8[r] = xtime(x4[r]);
    end
    res = '0;
    for (int r = 0; r < 4; r++) begin
      i1 = 2'(r + 1);
      i2 = 2'(r + 2);
      i3 = 2'(r + 3);
      res[8*r +: 8] = (x8[r]  ^ x4[r]  ^ x2[r])
                    ^ (x8[i1] ^ x2[i1] ^ a[i1])
                    ^ (x8[i2] ^ x4[i2] ^ a[i2])
                    ^ (x8[i3] ^ a[i3]);
    end
    return res;
  endfunction

  function automatic logic [127:0] invMix(input logic [127:0] s);
    logic [127:0] res;
    for (int c = 0; c < 4; c++) begin
      res[32*c +: 32] = invMixCol(s[32*c +: 32]);
    end
    return res;
  endfunction

  logic [127:0] w_add_key;
  logic         w_out_load;
  logic         w_stage_valid;
  logic [127:0] w_stage_result;
  logic         w_stage_last;

  logic               r_out_valid;
  logic [127:0]       r_out_state;
  logic               r_out_last;
  logic [CNT_W-1:0]   r_blk_cnt;

  assign w_add_key  = in_state ^ in_key;
  assign w_out_load = !r_out_valid || out_ready;

`ifdef INV_MIX_PIPE2_EN
  logic         r_s1_valid;
  logic [127:0] r_s1_state;
  logic         r_s1_last;
  logic         w_s1_load;

  assign w_s1_load = !r_s1_valid || w_out_load;
  assign in_ready  = w_s1_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_state <= '0;
      r_s1_last  <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_state <= w_add_key;
        r_s1_last  <= in_last;
      end
    end
  end

  assign w_stage_valid  = r_s1_valid;
  assign w_stage_result = r_s1_last ? r_s1_state : invMix(r_s1_state);
  assign w_stage_last   = r_s1_last;
`else
  assign in_ready       = w_out_load;
  assign w_stage_valid  = in_valid;
  assign w_stage_result = in_last ? w_add_key : invMix(w_add_key);
  assign w_stage_last   = in_last;
`endif

  // Output data only changes on a load with valid data, so it holds under backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_state <= '0;
      r_out_last  <= 1'b0;
    end else if (w_out_load) begin
      r_out_valid <= w_stage_valid;
      if (w_stage_valid) begin
        r_out_state <= w_stage_result;
        r_out_last  <= w_stage_last;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blk_cnt <= '0;
    end else if (r_out_valid && out_ready && r_out_last) begin
      r_blk_cnt <= r_blk_cnt + CNT_W'(1);
    end
  end

  assign out_valid = r_out_valid;
  assign out_state = r_out_state;
  assign out_last  = r_out_last;
  assign blk_cnt   = r_blk_cnt;

endmodule

// File: tb/tb_inv_round_tail.sv
// Self-checking bench for inv_round_tail: scoreboard of expected rounds, checked as outputs transfer.
// Follows INV_MIX_PIPE2_EN for the expected latency and capacity.
module tb_inv_round_tail;

`ifdef INV_MIX_PIPE2_EN
  localparam int LAT = 2;
  localparam int CAP = 2;
`else
  localparam int LAT = 1;
  localparam int CAP = 1;
`endif
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     in_state;
  logic [127:0]     in_key;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_state;
  logic             out_last;
  logic [CNT_W-1:0] blk_cnt;

  typedef struct {
    logic [127:0] st;
    logic         last;
    int           inCyc;
  } exp_t;

  typedef struct {
    bit           iX;
    bit           oX;
    bit           outV;
    bit           inRdy;
    int           cyc;
    logic [127:0] st;
    logic         last;
  } smp_t;

  exp_t             sbQ[$];
  int               passCnt = 0;
  int               totalCnt = 0;
  int               cycleNo = 0;
  logic [CNT_W-1:0] expCnt = '0;

  inv_round_tail #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_key    (in_key),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .out_last  (out_last),
    .blk_cnt   (blk_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: plain shift-and-add GF(2^8) multiply and the textbook InvMixColumns formula
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] modelRound(input logic [127:0] st, input logic [127:0] ky, input logic last);
    logic [127:0] s, r;
    s = st ^ ky;
    if (last) return s;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) begin
        r[32*c + 8*k +: 8] = gfMul(8'h0e, s[32*c + 8*k +: 8])
                           ^ gfMul(8'h0b, s[32*c + 8*((k+1)%4) +: 8])
                           ^ gfMul(8'h0d, s[32*c + 8*((k+2)%4) +: 8])
                           ^ gfMul(8'h09, s[32*c + 8*((k+3)%4) +: 8]);
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Samples handshakes and outputs mid-cycle, then advances to just after the next rising edge
  task automatic stepCycle(output smp_t s);
    @(negedge clk);
    s.iX    = in_valid && in_ready;
    s.oX    = out_valid && out_ready;
    s.outV  = out_valid;
    s.inRdy = in_ready;
    s.cyc   = cycleNo;
    s.st    = out_state;
    s.last  = out_last;
    @(posedge clk);
    #1;
    cycleNo++;
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    sbQ.delete();
    expCnt = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_state = '0;
    in_key = '0;
    in_last = 1'b0;
    out_ready = 1'b1;
    #12;
    totalCnt++; if (out_valid !== 1'b0) $display("[TB] FAIL rst_out_valid: got %b want 0", out_valid); else passCnt++;
    totalCnt++; if (in_ready !== 1'b1) $display("[TB] FAIL rst_in_ready: got %b want 1", in_ready); else passCnt++;
    totalCnt++; if (out_state !== 128'h0) $display("[TB] FAIL rst_out_state: got %h want 0", out_state); else passCnt++;
    totalCnt++; if (out_last !== 1'b0) $display("[TB] FAIL rst_out_last: got %b want 0", out_last); else passCnt++;
    totalCnt++; if (blk_cnt !== 4'd0) $display("[TB] FAIL rst_blk_cnt: got %0d want 0", blk_cnt); else passCnt++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_inv_mix_vector();
    smp_t s;
    exp_t e;
    int got = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_state = {64'h0, 32'h9d58dc9f, 32'hbca14d8e};
    in_key = '0;
    in_last = 1'b0;
    for (int t = 0; t < 10 && got < 1; t++) begin
      stepCycle(s);
      if (s.iX) begin
        sbQ.push_back('{{64'h0, 32'h5c220af2, 32'h455313db}, 1'b0, s.cyc});
        in_valid = 1'b0;
      end
      if (s.oX && sbQ.size() > 0) begin
        e = sbQ.pop_front();
        got++;
        totalCnt++; if (s.st !== e.st) $display("[TB] FAIL imc_vector: got %h want %h", s.st, e.st); else passCnt++;
        totalCnt++; if (s.last !== e.last) $display("[TB] FAIL imc_last: got %b want %b", s.last, e.last); else passCnt++;
      end
    end
    totalCnt++; if (got !== 1) $display("[TB] FAIL imc_timeout: got %0d outputs want 1", got); else passCnt++;
  endtask

  task automatic test_last_bypass();
    smp_t s;
    exp_t e;
    int got = 0;
    totalCnt++; if (blk_cnt !== 4'd0) $display("[TB] FAIL bypass_cnt_before: got %0d want 0", blk_cnt); else passCnt++;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_state = 128'h00112233445566778899aabbccddeeff;
    in_key = 128'hffeeddccbbaa99887766554433221100;
    in_last = 1'b1;
    for (int t = 0; t < 10 && got < 1; t++) begin
      stepCycle(s);
      if (s.iX) begin
        sbQ.push_back('{{128{1'b1}}, 1'b1, s.cyc});
        in_valid = 1'b0;
      end
      if (s.oX && sbQ.size() > 0) begin
        e = sbQ.pop_front();
        got++;
        if (e.last) expCnt++;
        totalCnt++; if (s.st !== e.st) $display("[TB] FAIL bypass_state: got %h want %h", s.st, e.st); else passCnt++;
        totalCnt++; if (s.last !== e.last) $display("[TB] FAIL bypass_last: got %b want %b", s.last, e.last); else passCnt++;
      end
    end
    totalCnt++; if (got !== 1) $display("[TB] FAIL bypass_timeout: got %0d outputs want 1", got); else passCnt++;
    totalCnt++; if (blk_cnt !== 4'd1) $display("[TB] FAIL bypass_cnt_after: got %0d want 1", blk_cnt); else passCnt++;
  endtask

  task automatic test_back_to_back();
    logic [127:0] st [8];
    logic [127:0] ky [8];
    logic         ls [8];
    smp_t s;
    exp_t e;
    int sent = 0, got = 0, lastOut = -1;
    for (int i = 0; i < 8; i++) begin
      st[i] = rand128();
      ky[i] = rand128();
      ls[i] = (i % 3 == 0);
    end
    out_ready = 1'b1;
    for (int t = 0; t < 40 && got < 8; t++) begin
      in_valid = (sent < 8);
      if (sent < 8) begin
        in_state = st[sent];
        in_key = ky[sent];
        in_last = ls[sent];
      end
      stepCycle(s);
      if (s.iX) begin
        sbQ.push_back('{modelRound(st[sent], ky[sent], ls[sent]), ls[sent], s.cyc});
        sent++;
      end
      if (s.oX) begin
        if (sbQ.size() == 0) begin
          totalCnt++; $display("[TB] FAIL b2b_extra: got output %h want none", s.st);
        end else begin
          e = sbQ.pop_front();
          got++;
          if (e.last) expCnt++;
          totalCnt++; if (s.st !== e.st) $display("[TB] FAIL b2b_state: got %h want %h", s.st, e.st); else passCnt++;
          totalCnt++; if (s.last !== e.last) $display("[TB] FAIL b2b_last: got %b want %b", s.last, e.last); else passCnt++;
          totalCnt++; if (s.cyc - e.inCyc !== LAT) $display("[TB] FAIL b2b_latency: got %0d want %0d", s.cyc - e.inCyc, LAT); else passCnt++;
          if (lastOut >= 0) begin
            totalCnt++; if (s.cyc !== lastOut + 1) $display("[TB] FAIL b2b_gap: got cycle %0d want %0d", s.cyc, lastOut + 1); else passCnt++;
          end
          lastOut = s.cyc;
        end
      end
    end
    in_valid = 1'b0;
    totalCnt++; if (got !== 8) $display("[TB] FAIL b2b_count: got %0d want 8", got); else passCnt++;
    totalCnt++; if (blk_cnt !== expCnt) $display("[TB] FAIL b2b_blk_cnt: got %0d want %0d", blk_cnt, expCnt); else passCnt++;
  endtask

  task automatic test_backpressure();
    logic [127:0] st [6];
    logic [127:0] ky [6];
    logic         ls [6];
    logic [127:0] holdSt = '0;
    bit   holdSeen = 0;
    smp_t s;
    exp_t e;
    int sent = 0, got = 0, acceptedHold = 0;
    for (int i = 0; i < 6; i++) begin
      st[i] = rand128();
      ky[i] = rand128();
      ls[i] = (i % 2 == 1);
    end
    for (int t = 0; t < 60 && got < 6; t++) begin
      out_ready = (t >= 5);
      in_valid = (sent < 6);
      if (sent < 6) begin
        in_state = st[sent];
        in_key = ky[sent];
        in_last = ls[sent];
      end
      stepCycle(s);
      if (t < 5) begin
        if (s.iX) acceptedHold++;
        if (s.outV) begin
          if (holdSeen) begin
            totalCnt++; if (s.st !== holdSt) $display("[TB] FAIL bp_stable: got %h want %h", s.st, holdSt); else passCnt++;
          end else begin
            holdSeen = 1;
            holdSt = s.st;
          end
        end
        if (t == 4) begin
          totalCnt++; if (s.inRdy !== 1'b0) $display("[TB] FAIL bp_in_ready: got %b want 0", s.inRdy); else passCnt++;
          totalCnt++; if (acceptedHold !== CAP) $display("[TB] FAIL bp_capacity: got %0d want %0d", acceptedHold, CAP); else passCnt++;
        end
      end
      if (s.iX) begin
        sbQ.push_back('{modelRound(st[sent], ky[sent], ls[sent]), ls[sent], s.cyc});
        sent++;
      end
      if (s.oX) begin
        if (sbQ.size() == 0) begin
          totalCnt++; $display("[TB] FAIL bp_extra: got output %h want none", s.st);
        end else begin
          e = sbQ.pop_front();
          got++;
          if (e.last) expCnt++;
          totalCnt++; if (s.st !== e.st) $display("[TB] FAIL bp_state: got %h want %h", s.st, e.st); else passCnt++;
          totalCnt++; if (s.last !== e.last) $display("[TB] FAIL bp_last: got %b want %b", s.last, e.last); else passCnt++;
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    totalCnt++; if (got !== 6) $display("[TB] FAIL bp_count: got %0d want 6", got); else passCnt++;
    totalCnt++; if (blk_cnt !== expCnt) $display("[TB] FAIL bp_blk_cnt: got %0d want %0d", blk_cnt, expCnt); else passCnt++;
  endtask

  task automatic test_counter_wrap();
    logic [127:0] st, ky;
    smp_t s;
    exp_t e;
    int sent = 0, got = 0;
    pulseReset();
    totalCnt++; if (blk_cnt !== 4'd0) $display("[TB] FAIL wrap_cnt_start: got %0d want 0", blk_cnt); else passCnt++;
    out_ready = 1'b1;
    in_last = 1'b1;
    st = rand128();
    ky = rand128();
    for (int t = 0; t < 60 && got < 17; t++) begin
      in_valid = (sent < 17);
      in_state = st;
      in_key = ky;
      stepCycle(s);
      if (s.iX) begin
        sbQ.push_back('{st ^ ky, 1'b1, s.cyc});
        sent++;
        st = rand128();
        ky = rand128();
      end
      if (s.oX && sbQ.size() > 0) begin
        e = sbQ.pop_front();
        got++;
        totalCnt++; if (s.st !== e.st) $display("[TB] FAIL wrap_state: got %h want %h", s.st, e.st); else passCnt++;
      end
    end
    in_valid = 1'b0;
    totalCnt++; if (got !== 17) $display("[TB] FAIL wrap_count: got %0d want 17", got); else passCnt++;
    totalCnt++; if (blk_cnt !== 4'd1) $display("[TB] FAIL wrap_blk_cnt: got %0d want 1", blk_cnt); else passCnt++;
    expCnt = 4'd1;
  endtask

  task automatic test_reset_midstream();
    logic [127:0] st, ky;
    smp_t s;
    exp_t e;
    int got = 0;
    out_ready = 1'b0;
    in_last = 1'b1;
    for (int t = 0; t < 2; t++) begin
      in_valid = 1'b1;
      in_state = rand128();
      in_key = rand128();
      stepCycle(s);
    end
    in_valid = 1'b0;
    totalCnt++; if (out_valid !== 1'b1) $display("[TB] FAIL mid_pre_valid: got %b want 1", out_valid); else passCnt++;
    totalCnt++; if (blk_cnt !== expCnt) $display("[TB] FAIL mid_pre_cnt: got %0d want %0d", blk_cnt, expCnt); else passCnt++;
    #2;
    rst = 1'b1;
    #1;
    totalCnt++; if (out_valid !== 1'b0) $display("[TB] FAIL mid_out_valid: got %b want 0", out_valid); else passCnt++;
    totalCnt++; if (blk_cnt !== 4'd0) $display("[TB] FAIL mid_blk_cnt: got %0d want 0", blk_cnt); else passCnt++;
    totalCnt++; if (in_ready !== 1'b1) $display("[TB] FAIL mid_in_ready: got %b want 1", in_ready); else passCnt++;
    sbQ.delete();
    expCnt = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      stepCycle(s);
      totalCnt++; if (s.outV !== 1'b0) $display("[TB] FAIL mid_ghost_output: got valid %b want 0", s.outV); else passCnt++;
    end
    st = rand128();
    ky = rand128();
    in_valid = 1'b1;
    in_state = st;
    in_key = ky;
    in_last = 1'b0;
    for (int t = 0; t < 10 && got < 1; t++) begin
      stepCycle(s);
      if (s.iX) begin
        sbQ.push_back('{modelRound(st, ky, 1'b0), 1'b0, s.cyc});
        in_valid = 1'b0;
      end
      if (s.oX && sbQ.size() > 0) begin
        e = sbQ.pop_front();
        got++;
        totalCnt++; if (s.st !== e.st) $display("[TB] FAIL mid_after_state: got %h want %h", s.st, e.st); else passCnt++;
      end
    end
    totalCnt++; if (got !== 1) $display("[TB] FAIL mid_after_count: got %0d want 1", got); else passCnt++;
  endtask

  initial begin
    test_reset();
    test_inv_mix_vector();
    test_last_bypass();
    test_back_to_back();
    test_backpressure();
    test_counter_wrap();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
